// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   localparam int STATUS_FULL    = 0;
   localparam int STATUS_EMPTY   = 1;
   localparam int STATUS_BUSY    = 2;
   localparam int STATUS_OVF     = 3;
   localparam int STATUS_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with first-word fall-through read data.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Purpose: memory-mapped 8N1 UART transmitter with a TX FIFO and combinational status reads.
// Latency: a store into an idle, empty block drives the start bit one edge after capture.
// Backpressure: none to the core; stores to a full FIFO are dropped and flagged as overflow.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter logic [15:0] CLK_DIV    = 16'd868,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_r,
   input  logic [3:0]  ram_w,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_out,
   output logic        sel,
   output logic [31:0] rd_data,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;

   logic [1:0]  reg_idx;
   logic        push_req, w1c, ovf_set, overflow_q, busy, pop;
   logic [7:0]  fifo_dout;
   logic        fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0] count_ext, status;
   logic [3:0]  count_sat;
   logic        unused_bits;

   assign reg_idx  = ram_addr[3:2];
   assign sel      = (ram_addr[31:4] == BASE_ADDR[31:4]);
   assign push_req = sel & (reg_idx == REG_TXDATA) & ram_w[0];
   assign w1c      = sel & (reg_idx == REG_STATUS) & ram_w[0] & ram_out[STATUS_OVF];
   assign ovf_set  = push_req & fifo_full & ~pop;
   assign busy     = (state_q != IDLE);

   // Loads have no side effects, so the strobe and the unused lanes carry no function here.
   assign unused_bits = ^{ram_r, ram_w[3:1], ram_out[31:8], ram_addr[1:0]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .din   (ram_out[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign count_ext = 32'(fifo_count);
   assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

   always_comb begin
      status                               = '0;
      status[STATUS_FULL]                  = fifo_full;
      status[STATUS_EMPTY]                 = fifo_empty;
      status[STATUS_BUSY]                  = busy;
      status[STATUS_OVF]                   = overflow_q;
      status[STATUS_CNT_LSB+3:STATUS_CNT_LSB] = count_sat;
   end

   assign rd_data = (sel && reg_idx == REG_STATUS) ? status : 32'h0;

   // A new overflow in the same cycle as a clear must stay visible.
   always_ff @(posedge clk) begin
      if (rst)          overflow_q <= 1'b0;
      else if (ovf_set) overflow_q <= 1'b1;
      else if (w1c)     overflow_q <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      pop     = 1'b0;
      tx      = 1'b1;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               cnt_d   = CLK_DIV - 16'd1;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (cnt_q == '0) begin
               cnt_d   = CLK_DIV - 16'd1;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         DATA: begin
            tx = shift_q[0];
            if (cnt_q == '0) begin
               cnt_d   = CLK_DIV - 16'd1;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         STOP: begin
            // Chain straight into the next start bit so queued bytes leave with no idle gap.
            if (cnt_q == '0) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  cnt_d   = CLK_DIV - 16'd1;
                  bit_d   = '0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
